instr_decode_stage: RTL and testbench

//  Pipelined decode stage of the 9-bit CPU, generalised over operand width.

---
 rtl/instr_decode_stage_pkg.sv | 48 ++++
 rtl/instr_field_decode.sv | 30 +++
 rtl/instr_decode_stage.sv | 151 +++++++++++++++
 tb/tb_instr_decode_stage.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_decode_stage_pkg.sv
// Shared types, opcode constants and the opcode-to-class lookup for the decode stage.
package instr_decode_stage_pkg;

    typedef enum logic [2:0] {
        CLS_VAL,
        CLS_MOV,
        CLS_MEM,
        CLS_INC,
        CLS_BR,
        CLS_ALU,
        CLS_SHF,
        CLS_FUNC
    } dec_class_t;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_PREFIX,
        ST_HALT
    } dec_state_t;

    localparam logic [4:0] OP_MOV_LO = 5'b00010;
    localparam logic [4:0] OP_MEM_LO = 5'b10000;
    localparam logic [4:0] OP_INC_LO = 5'b10010;
    localparam logic [4:0] OP_BR_LO  = 5'b10100;
    localparam logic [4:0] OP_SETH   = 5'b11001;
    localparam logic [4:0] OP_MATH   = 5'b11010;
    localparam logic [4:0] OP_MTHS   = 5'b11011;
    localparam logic [4:0] OP_SHF_LO = 5'b11100;
    localparam logic [4:0] OP_FLIP   = 5'b11110;
    localparam logic [4:0] OP_FUNC   = 5'b11111;

    localparam logic [3:0] FN_DONE   = 4'b1111;

    // Opcode space is laid out in ascending class ranges, so lower bounds suffice.
    // seth has no class of its own and is never emitted; it maps to VAL.
    function automatic dec_class_t classify(input logic [4:0] op);
        if (op < OP_MOV_LO)      classify = CLS_VAL;
        else if (op < OP_MEM_LO) classify = CLS_MOV;
        else if (op < OP_INC_LO) classify = CLS_MEM;
        else if (op < OP_BR_LO)  classify = CLS_INC;
        else if (op < OP_SETH)   classify = CLS_BR;
        else if (op < OP_MATH)   classify = CLS_VAL;
        else if (op < OP_SHF_LO) classify = CLS_ALU;
        else if (op < OP_FLIP)   classify = CLS_SHF;
        else                     classify = CLS_FUNC;
    endfunction

endpackage

// File: rtl/instr_field_decode.sv
// Purely combinational field decode of one fetched word: class, destination,
// register bank and the seth/done markers used by the stage control.
module instr_field_decode
    import instr_decode_stage_pkg::*;
#(
    parameter int OPR_W = 4
) (
    input  logic [OPR_W+4:0] in_instr,
    output dec_class_t       dec_class,
    output logic [3:0]       dst,
    output logic             bank,
    output logic             is_seth,
    output logic             is_done
);

    logic [4:0] opcode;
    logic [3:0] fn;

    assign opcode = in_instr[OPR_W+4:OPR_W];
    assign fn     = in_instr[3:0];

    always_comb begin
        dec_class = classify(opcode);
        dst       = (dec_class == CLS_MOV) ? opcode[3:0] : 4'd0;
        bank      = (opcode == OP_MTHS);
        is_seth   = (opcode == OP_SETH);
        is_done   = (opcode == OP_FUNC) && (fn == FN_DONE);
    end

endmodule

// File: rtl/instr_decode_stage.sv
// Decode stage: one registered decode bundle, sticky seth prefix latch and RUN/PREFIX/HALT control.
// Defining DECODE_STATS_EN adds saturating stat_instr / stat_stall counters.
module instr_decode_stage
    import instr_decode_stage_pkg::*;
#(
    parameter int OPR_W = 4,
    parameter int EXT_W = 4
`ifdef DECODE_STATS_EN
    ,
    parameter int STAT_W = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              resume,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPR_W+4:0]  in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output dec_class_t        out_class,
    output logic [4:0]        out_opcode,
    output logic [3:0]        out_dst,
    output logic [OPR_W-1:0]  out_opr,
    output logic              out_bank,
    output logic [EXT_W-1:0]  out_ext,
    output logic              out_ext_vld,
    output logic              out_halt,
    output logic              halted
`ifdef DECODE_STATS_EN
    ,
    output logic [STAT_W-1:0] stat_instr,
    output logic [STAT_W-1:0] stat_stall
`endif
);

    localparam int INSTR_W = 5 + OPR_W;

    dec_state_t       state;
    dec_state_t       state_nxt;
    logic [EXT_W-1:0] ext;
    logic             ext_pend;
    logic             accept;

    dec_class_t       dec_class;
    logic [3:0]       dec_dst;
    logic             dec_bank;
    logic             dec_seth;
    logic             dec_done;

    instr_field_decode #(.OPR_W(OPR_W)) u_fields (
        .in_instr  (in_instr),
        .dec_class (dec_class),
        .dst       (dec_dst),
        .bank      (dec_bank),
        .is_seth   (dec_seth),
        .is_done   (dec_done)
    );

    // A flush cycle never accepts, so flush trivially wins over a simultaneous transfer.
    assign in_ready = (state != ST_HALT) && (!out_valid || out_ready) && !flush;
    assign accept   = in_valid && in_ready;
    assign halted   = (state == ST_HALT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_RUN;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN, ST_PREFIX: begin
                if (flush)         state_nxt = ST_RUN;
                else if (accept) begin
                    if (dec_seth)      state_nxt = ST_PREFIX;
                    else if (dec_done) state_nxt = ST_HALT;
                    else               state_nxt = ST_RUN;
                end
            end
            ST_HALT: begin
                if (resume) state_nxt = ST_RUN;
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    // seth words are absorbed here and never reach the output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ext      <= '0;
            ext_pend <= 1'b0;
        end else if (flush) begin
            ext_pend <= 1'b0;
        end else if (accept) begin
            if (dec_seth) begin
                ext      <= in_instr[EXT_W-1:0];
                ext_pend <= 1'b1;
            end else begin
                ext_pend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_class   <= CLS_VAL;
            out_opcode  <= '0;
            out_dst     <= '0;
            out_opr     <= '0;
            out_bank    <= 1'b0;
            out_ext     <= '0;
            out_ext_vld <= 1'b0;
            out_halt    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept && !dec_seth) begin
            out_valid   <= 1'b1;
            out_class   <= dec_class;
            out_opcode  <= in_instr[INSTR_W-1:OPR_W];
            out_dst     <= dec_dst;
            out_opr     <= in_instr[OPR_W-1:0];
            out_bank    <= dec_bank;
            out_ext     <= ext_pend ? ext : '0;
            out_ext_vld <= ext_pend;
            out_halt    <= dec_done;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef DECODE_STATS_EN
    localparam logic [STAT_W-1:0] STAT_ONE = {{(STAT_W-1){1'b0}}, 1'b1};

    // Counters saturate at all-ones and are cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_instr <= '0;
            stat_stall <= '0;
        end else begin
            if (out_valid && out_ready && !(&stat_instr))
                stat_instr <= stat_instr + STAT_ONE;
            if (out_valid && !out_ready && !(&stat_stall))
                stat_stall <= stat_stall + STAT_ONE;
        end
    end
`endif

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed self-checking bench for instr_decode_stage (default OPR_W=4, EXT_W=4).
// Stat counter checks are compiled in only when DECODE_STATS_EN is defined.
module tb_instr_decode_stage;
    import instr_decode_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        resume;
    logic        in_valid;
    logic        in_ready;
    logic [8:0]  in_instr;
    logic        out_valid;
    logic        out_ready;
    dec_class_t  out_class;
    logic [4:0]  out_opcode;
    logic [3:0]  out_dst;
    logic [3:0]  out_opr;
    logic        out_bank;
    logic [3:0]  out_ext;
    logic        out_ext_vld;
    logic        out_halt;
    logic        halted;
`ifdef DECODE_STATS_EN
    logic [15:0] stat_instr;
    logic [15:0] stat_stall;
`endif

    int checks = 0;
    int errors = 0;

    instr_decode_stage dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .resume      (resume),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_class   (out_class),
        .out_opcode  (out_opcode),
        .out_dst     (out_dst),
        .out_opr     (out_opr),
        .out_bank    (out_bank),
        .out_ext     (out_ext),
        .out_ext_vld (out_ext_vld),
        .out_halt    (out_halt),
        .halted      (halted)
`ifdef DECODE_STATS_EN
        ,
        .stat_instr  (stat_instr),
        .stat_stall  (stat_stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic v, input logic [8:0] instr, input logic rdy,
                                 input logic fl, input logic rs);
        in_valid  = v;
        in_instr  = instr;
        out_ready = rdy;
        flush     = fl;
        resume    = rs;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b0, 9'd0, 1'b1, 1'b0, 1'b0);
        #8;
        checkOutput("rst_out_valid", out_valid, 0);
        checkOutput("rst_halted", halted, 0);
        checkOutput("rst_in_ready", in_ready, 1);
        checkOutput("rst_out_ext_vld", out_ext_vld, 0);
        checkOutput("rst_out_opcode", out_opcode, 0);
        checkOutput("rst_out_class", out_class, CLS_VAL);
        #4;
        rst_n = 1'b1;
        tick();

        // Stream: movc r, incr, mths add on consecutive cycles.
        $display("[TB] stream test");
        applyStimulus(1'b1, 9'b00010_0000, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("s1_valid", out_valid, 1);
        checkOutput("s1_class", out_class, CLS_MOV);
        checkOutput("s1_dst", out_dst, 2);
        checkOutput("s1_bank", out_bank, 0);
        applyStimulus(1'b1, 9'b10010_0011, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("s2_valid", out_valid, 1);
        checkOutput("s2_class", out_class, CLS_INC);
        checkOutput("s2_dst", out_dst, 0);
        checkOutput("s2_opr", out_opr, 3);
        applyStimulus(1'b1, 9'b11011_0001, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("s3_valid", out_valid, 1);
        checkOutput("s3_class", out_class, CLS_ALU);
        checkOutput("s3_bank", out_bank, 1);
        checkOutput("s3_opcode", out_opcode, 5'b11011);
        applyStimulus(1'b0, 9'd0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("s4_drain", out_valid, 0);

        // Prefix: seth 3, seth 9, movx 1, then an unprefixed vall.
        $display("[TB] prefix test");
        applyStimulus(1'b1, 9'b11001_0011, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("p1_seth_hidden", out_valid, 0);
        checkOutput("p1_in_ready", in_ready, 1);
        applyStimulus(1'b1, 9'b11001_1001, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("p2_seth_hidden", out_valid, 0);
        applyStimulus(1'b1, 9'b00011_0001, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("p3_valid", out_valid, 1);
        checkOutput("p3_ext", out_ext, 9);
        checkOutput("p3_ext_vld", out_ext_vld, 1);
        checkOutput("p3_dst", out_dst, 3);
        applyStimulus(1'b1, 9'b00000_0101, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("p4_ext_vld", out_ext_vld, 0);
        checkOutput("p4_ext", out_ext, 0);
        checkOutput("p4_class", out_class, CLS_VAL);
        applyStimulus(1'b0, 9'd0, 1'b1, 1'b0, 1'b0);
        tick();

        // Backpressure: output held for 4 cycles.
        $display("[TB] stall test");
        applyStimulus(1'b1, 9'b00100_0111, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("b0_valid", out_valid, 1);
        applyStimulus(1'b1, 9'b10011_0010, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("b0_in_ready", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("b_hold_valid", out_valid, 1);
            checkOutput("b_hold_opcode", out_opcode, 5'b00100);
            checkOutput("b_hold_opr", out_opr, 7);
            checkOutput("b_hold_dst", out_dst, 4);
            checkOutput("b_hold_in_ready", in_ready, 0);
        end
`ifdef DECODE_STATS_EN
        checkOutput("b_stat_stall", stat_stall, 4);
        checkOutput("b_stat_instr", stat_instr, 5);
`endif
        applyStimulus(1'b1, 9'b10011_0010, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("b5_valid", out_valid, 1);
        checkOutput("b5_opcode", out_opcode, 5'b10011);
        applyStimulus(1'b0, 9'd0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("b6_drain", out_valid, 0);
`ifdef DECODE_STATS_EN
        checkOutput("b6_stat_instr", stat_instr, 7);
        checkOutput("b6_stat_stall", stat_stall, 4);
`endif

        // Halt: func done with an early resume that must be ignored.
        $display("[TB] halt test");
        applyStimulus(1'b1, 9'b11111_1111, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("h1_valid", out_valid, 1);
        checkOutput("h1_halt", out_halt, 1);
        checkOutput("h1_class", out_class, CLS_FUNC);
        checkOutput("h1_halted", halted, 1);
        applyStimulus(1'b1, 9'b00000_0001, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("h1_in_ready", in_ready, 0);
        tick();
        checkOutput("h2_valid", out_valid, 0);
        checkOutput("h2_halted", halted, 1);
        checkOutput("h2_in_ready", in_ready, 0);
        applyStimulus(1'b1, 9'b00000_0001, 1'b1, 1'b0, 1'b1);
        tick();
        applyStimulus(1'b1, 9'b00000_0001, 1'b1, 1'b0, 1'b0);
        #1;
        checkOutput("h3_halted", halted, 0);
        checkOutput("h3_not_taken", out_valid, 0);
        checkOutput("h3_in_ready", in_ready, 1);
        tick();
        checkOutput("h4_valid", out_valid, 1);
        checkOutput("h4_opr", out_opr, 1);
        checkOutput("h4_halt", out_halt, 0);
        applyStimulus(1'b0, 9'd0, 1'b1, 1'b0, 1'b0);
        tick();

        // Flush: drops a pending seth and blocks a simultaneous word.
        $display("[TB] flush test");
        applyStimulus(1'b1, 9'b11001_0101, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 9'b00000_0110, 1'b1, 1'b1, 1'b0);
        #1;
        checkOutput("f1_in_ready", in_ready, 0);
        tick();
        checkOutput("f1_no_accept", out_valid, 0);
        applyStimulus(1'b1, 9'b00000_0110, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("f2_valid", out_valid, 1);
        checkOutput("f2_ext_vld", out_ext_vld, 0);
        checkOutput("f2_ext", out_ext, 0);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("f3_held", out_valid, 1);
        applyStimulus(1'b0, 9'd0, 1'b0, 1'b1, 1'b0);
        tick();
        checkOutput("f4_dropped", out_valid, 0);

        // Asynchronous reset in PREFIX with a stale bundle in the fields.
        $display("[TB] async reset test");
        applyStimulus(1'b1, 9'b11001_0110, 1'b1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 9'd0, 1'b1, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("r_valid", out_valid, 0);
        checkOutput("r_opr", out_opr, 0);
        checkOutput("r_halted", halted, 0);
        checkOutput("r_in_ready", in_ready, 1);
        #2;
        rst_n = 1'b1;
        tick();
        applyStimulus(1'b1, 9'b00011_0100, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("r2_valid", out_valid, 1);
        checkOutput("r2_ext_vld", out_ext_vld, 0);
        checkOutput("r2_ext", out_ext, 0);
        checkOutput("r2_class", out_class, CLS_MOV);
        applyStimulus(1'b0, 9'd0, 1'b1, 1'b0, 1'b0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
